// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock through a full-subtractor trial chain.
// Define APPROX_SUB_EN to approximate the low APPROX_BITS bits of the trial subtraction.
module seq_divider #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle once the
    // result outputs are updated, and a start in that same cycle is accepted.
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] q_q;
    // The partial remainder's ninth bit only exists inside the shifted trial value;
    // after a restore/accept decision it is always 0, so only WIDTH bits are stored.
    logic [WIDTH-1:0] r_q;
    logic [IDX_W-1:0] idx_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   subtrahend;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             no_borrow;

    always_comb begin
        shifted    = {r_q, dvd_q[idx_q]};
        subtrahend = {1'b0, dvs_q};
        trial      = '0;
        borrow     = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
`ifdef APPROX_SUB_EN
            if (i < APPROX_BITS) begin
                trial[i] = shifted[i] ^ subtrahend[i];
            end else begin
                trial[i] = shifted[i] ^ subtrahend[i] ^ borrow;
                borrow   = (~shifted[i] & subtrahend[i]) |
                           (~(shifted[i] ^ subtrahend[i]) & borrow);
            end
`else
            trial[i] = shifted[i] ^ subtrahend[i] ^ borrow;
            borrow   = (~shifted[i] & subtrahend[i]) |
                       (~(shifted[i] ^ subtrahend[i]) & borrow);
`endif
        end
        no_borrow = ~borrow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            dbz_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q       <= dividend;
                        dvs_q       <= divisor;
                        idx_q       <= IDX_W'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            q_q   <= '1;
                            r_q   <= dividend;
                            dbz_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            q_q   <= '0;
                            r_q   <= '0;
                            dbz_q <= 1'b0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q        <= no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    q_q[idx_q] <= no_borrow;
                    if (idx_q == '0) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= q_q;
                    remainder   <= r_q;
                    div_by_zero <= dbz_q;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: driver pushes expected results, a negedge monitor pops and compares.
module tb_seq_divider;

    localparam int W  = 8;
    localparam int EW = 2 * W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic [EW-1:0] exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int exp_cnt   = 0;
    logic prev_done = 1'b0;

    seq_divider #(.WIDTH(W), .APPROX_BITS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                logic [EW-1:0] exp;
                done_cnt++;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high two cycles in a row, required one");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: q=%0d r=%0d dbz=%0b, required no done", quotient, remainder, div_by_zero);
                end else begin
                    exp = exp_q.pop_front();
                    if ({div_by_zero, quotient, remainder} !== exp) begin
                        errors++;
                        $display("FAIL result: q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                                 quotient, remainder, div_by_zero, exp[2*W-1:W], exp[W-1:0], exp[2*W]);
                    end
                end
            end
            prev_done = done;
        end
    end

    // Waits at negedges for done; lat counts edges after the accepting edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required done", lat);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int exp_lat, input int exp_busy);
        int lat, bc;
        exp_q.push_back({ez, eq, er});
        exp_cnt++;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom_range(0, 255));
        divisor  = W'($urandom_range(0, 255));
        wait_done(lat, bc);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency %0d/%0d: got %0d, required %0d", a, b, lat, exp_lat);
        end
        checks++;
        if (bc != exp_busy) begin
            errors++;
            $display("FAIL busy_cycles %0d/%0d: got %0d, required %0d", a, b, bc, exp_busy);
        end
    endtask

    initial begin
        int lat, bc;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 8);
        do_div(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1, 0);
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 8);

        // back-to-back 100/10 with a start during CALC that must be dropped
        exp_q.push_back({1'b0, 8'd10, 8'd0});
        exp_cnt++;
        dividend = 8'd100;
        divisor  = 8'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        repeat (12) @(negedge clk);

        // reset in the middle of CALC aborts with no done
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 8);

`ifdef APPROX_SUB_EN
        do_div(8'd8, 8'd4, 8'd2, 8'd0, 1'b0, 9, 8);
        do_div(8'd2, 8'd3, 8'd255, 8'd3, 1'b0, 9, 8);
`else
        do_div(8'd8, 8'd4, 8'd2, 8'd0, 1'b0, 9, 8);
        do_div(8'd2, 8'd3, 8'd0, 8'd2, 1'b0, 9, 8);
        do_div(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, 1, 0);
        do_div(8'd7, 8'd200, 8'd0, 8'd7, 1'b0, 9, 8);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 8);
        do_div(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9, 8);
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (b == '0)
                do_div(a, b, 8'd255, a, 1'b1, 1, 0);
            else
                do_div(a, b, a / b, a % b, 1'b0, 9, 8);
        end
`endif

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d results never seen, required 0", exp_q.size());
        end
        checks++;
        if (done_cnt != exp_cnt) begin
            errors++;
            $display("FAIL done_count: got %0d, required %0d", done_cnt, exp_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
